// File: rtl/operand_forward_ctrl_pkg.sv
// Shared types and encodings for the EX-stage operand forwarding controller.
package operand_forward_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  load;
    } tracker_t;

    localparam tracker_t TRACKER_EMPTY = '0;

endpackage

// File: rtl/operand_forward_ctrl_compare.sv
// Per-operand comparator: picks the forwarding source for one rs and flags a load-use hit.
module fwd_select_compare
    import operand_forward_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  tracker_t              ex,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_we,
    output logic [1:0]            sel,
    output logic                  hazard
);

    logic ex_hit;
    logic mem_hit;

    // x0 is hardwired to zero, so a write to it is never a real producer.
    assign ex_hit  = ex.we && (ex.rd != '0) && (ex.rd == rs);
    assign mem_hit = mem_we && (mem_rd != '0) && (mem_rd == rs);

    assign hazard = ex_hit && ex.load;

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_hit && !ex.load) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/operand_forward_ctrl.sv
// ID-stage forwarding controller: registers EX operand-mux selects, detects load-use stalls
// and counts stall cycles.
module operand_forward_ctrl #(
    parameter int REG_ADDR_W = operand_forward_ctrl_pkg::REG_ADDR_W,
    parameter int COUNT_W    = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HOLD,
    input  logic                  FLUSH,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  ID_REG_WRITE,
    input  logic                  ID_MEM_READ,
    output logic [1:0]            FWD_SEL1,
    output logic [1:0]            FWD_SEL2,
    output logic                  STALL,
    output logic [COUNT_W-1:0]    STALL_COUNT
);

    import operand_forward_ctrl_pkg::*;

    tracker_t              ex_trk;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_we;

    logic [1:0] sel1_next;
    logic [1:0] sel2_next;
    logic       hazard1;
    logic       hazard2;

    fwd_select_compare u_cmp_rs1 (
        .rs     (ID_RS1),
        .ex     (ex_trk),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .sel    (sel1_next),
        .hazard (hazard1)
    );

    fwd_select_compare u_cmp_rs2 (
        .rs     (ID_RS2),
        .ex     (ex_trk),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .sel    (sel2_next),
        .hazard (hazard2)
    );

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign STALL = ID_VALID & ~FLUSH & (hazard1 | hazard2);

    // NOTE: all state here is flops updated with non-blocking assignments and a synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ex_trk      <= TRACKER_EMPTY;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            FWD_SEL1    <= FWD_REGFILE;
            FWD_SEL2    <= FWD_REGFILE;
            STALL_COUNT <= '0;
        end else if (!HOLD) begin
            mem_rd <= ex_trk.rd;
            mem_we <= ex_trk.we;
            if (FLUSH || STALL) begin
                // Bubble into EX: nothing to forward to, nothing to forward from.
                ex_trk   <= TRACKER_EMPTY;
                FWD_SEL1 <= FWD_REGFILE;
                FWD_SEL2 <= FWD_REGFILE;
                if (STALL && (STALL_COUNT != '1)) begin
                    STALL_COUNT <= STALL_COUNT + COUNT_W'(1);
                end
            end else begin
                ex_trk   <= '{rd: ID_RD, we: ID_REG_WRITE & ID_VALID, load: ID_MEM_READ & ID_VALID};
                FWD_SEL1 <= ID_VALID ? sel1_next : FWD_REGFILE;
                FWD_SEL2 <= ID_VALID ? sel2_next : FWD_REGFILE;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed self-checking bench for operand_forward_ctrl; expected selects flow through a scoreboard queue.
module tb_operand_forward_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          CLK;
    logic          RESET;
    logic          HOLD;
    logic          FLUSH;
    logic          ID_VALID;
    logic [AW-1:0] ID_RS1;
    logic [AW-1:0] ID_RS2;
    logic [AW-1:0] ID_RD;
    logic          ID_REG_WRITE;
    logic          ID_MEM_READ;
    logic [1:0]    FWD_SEL1;
    logic [1:0]    FWD_SEL2;
    logic          STALL;
    logic [CW-1:0] STALL_COUNT;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    operand_forward_ctrl #(.REG_ADDR_W(AW), .COUNT_W(CW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .HOLD         (HOLD),
        .FLUSH        (FLUSH),
        .ID_VALID     (ID_VALID),
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_RD        (ID_RD),
        .ID_REG_WRITE (ID_REG_WRITE),
        .ID_MEM_READ  (ID_MEM_READ),
        .FWD_SEL1     (FWD_SEL1),
        .FWD_SEL2     (FWD_SEL2),
        .STALL        (STALL),
        .STALL_COUNT  (STALL_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic mr);
        ID_VALID     = v;
        ID_RS1       = rs1;
        ID_RS2       = rs2;
        ID_RD        = rd;
        ID_REG_WRITE = we;
        ID_MEM_READ  = mr;
    endtask

    // Present one ID instruction, check STALL, then check the selects during its EX cycle.
    task automatic exec(input string tag, input logic v, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic we,
                        input logic mr, input logic [1:0] e1, input logic [1:0] e2, input logic es);
        logic [3:0] exp_sel;
        drive(v, rs1, rs2, rd, we, mr);
        #1;
        check({tag, " stall"}, 32'(STALL), 32'(es));
        exp_q.push_back({e1, e2});
        @(posedge CLK);
        #1;
        exp_sel = exp_q.pop_front();
        check({tag, " sel1"}, 32'(FWD_SEL1), 32'(exp_sel[3:2]));
        check({tag, " sel2"}, 32'(FWD_SEL2), 32'(exp_sel[1:0]));
    endtask

    initial begin
        RESET = 1'b0;
        HOLD  = 1'b0;
        FLUSH = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("reset sel1", 32'(FWD_SEL1), 32'd0);
        check("reset sel2", 32'(FWD_SEL2), 32'd0);
        check("reset count", 32'(STALL_COUNT), 32'd0);
        check("reset stall", 32'(STALL), 32'd0);
        RESET = 1'b1;

        // EX -> EX forwarding on operand 1
        exec("add x5", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("sub rs1=x5", 1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
        exec("nop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        // MEM -> EX forwarding on operand 2
        exec("add x5 b", 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("nop b", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("or rs2=x5", 1'b1, 5'd1, 5'd5, 5'd9, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0);

        // EX beats MEM
        exec("add x5 c1", 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("add x5 c2", 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("use x5 prio", 1'b1, 5'd5, 5'd5, 5'd10, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0);

        // Load-use: one stall, then MEM forwarding
        exec("lw x7", 1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        exec("add rs1=x7 stall", 1'b1, 5'd7, 5'd3, 5'd11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
        check("count after 1 stall", 32'(STALL_COUNT), 32'd1);
        exec("add rs1=x7 retry", 1'b1, 5'd7, 5'd3, 5'd11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
        check("count after retry", 32'(STALL_COUNT), 32'd1);

        // x0 destinations never forward or stall
        exec("lw x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        exec("add x0 after lw x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("use x0", 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        // FLUSH masks a load-use hazard and empties EX
        exec("lw x7 f", 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        FLUSH = 1'b1;
        exec("flushed use x7", 1'b1, 5'd7, 5'd7, 5'd13, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        FLUSH = 1'b0;
        exec("use x7 post flush", 1'b1, 5'd7, 5'd0, 5'd13, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
        check("count after flush", 32'(STALL_COUNT), 32'd1);

        // HOLD freezes everything across a pending stall
        exec("add x12", 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        exec("lw x13 rs1=x12", 1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
        HOLD = 1'b1;
        drive(1'b1, 5'd13, 5'd0, 5'd15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold stall", 32'(STALL), 32'd1);
            @(posedge CLK);
            #1;
            check("hold sel1", 32'(FWD_SEL1), 32'd1);
            check("hold sel2", 32'(FWD_SEL2), 32'd0);
            check("hold count", 32'(STALL_COUNT), 32'd1);
        end
        HOLD = 1'b0;
        exec("add rs1=x13 stall", 1'b1, 5'd13, 5'd0, 5'd15, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
        check("count after hold", 32'(STALL_COUNT), 32'd2);
        exec("add rs1=x13 retry", 1'b1, 5'd13, 5'd0, 5'd15, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);

        // Build the counter to 5, then reset in the middle of a stall
        for (int i = 0; i < 3; i++) begin
            exec("lw x14", 1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
            exec("use x14 stall", 1'b1, 5'd14, 5'd0, 5'd16, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
        end
        check("count at 5", 32'(STALL_COUNT), 32'd5);
        exec("lw x14 r", 1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 5'd14, 5'd0, 5'd16, 1'b1, 1'b0);
        #1;
        check("stall before reset", 32'(STALL), 32'd1);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("mid-stall reset sel1", 32'(FWD_SEL1), 32'd0);
        check("mid-stall reset sel2", 32'(FWD_SEL2), 32'd0);
        check("mid-stall reset count", 32'(STALL_COUNT), 32'd0);
        check("mid-stall reset stall", 32'(STALL), 32'd0);
        RESET = 1'b1;
        exec("use x14 after reset", 1'b1, 5'd14, 5'd0, 5'd16, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        // Saturation at all-ones
        for (int i = 0; i < 16; i++) begin
            exec("lw x20", 1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
            exec("use x20 stall", 1'b1, 5'd20, 5'd0, 5'd21, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
            check("sat count", 32'(STALL_COUNT), (i < 15) ? 32'(i + 1) : 32'd15);
        end

        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
